spimaster: RTL and testbench
============================

# spimaster

Byte-oriented SPI master (mode 0: CPOL=0, CPHA=0) generating `sck`, `mosi` and `cs` from the system clock and sampling `miso`. It is the initiating end of the link served by the existing SPI slave. It is used both to drive that slave in system-level benches and to talk to external SPI peripherals. A simple start/busy/done handshake moves one byte per transfer, and a `hold` input keeps chip-select asserted across multi-byte frames. `firstbyte` flags the first byte of each frame, mirroring the slave's first-byte flag.

## Interface
- `CLKDIV`, default 2: length of one `sck` half-period in `clk` cycles; legal values are ≥1.
- `clk` in 1: system clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `start` in 1: request a byte transfer; accepted only when `busy`=0.
- `hold` in 1: level input; keeps `cs` asserted after the current byte.
- `txdata` in 8: byte to send; latched on the cycle `start` is accepted.
- `rxdata` out 8: byte received on `miso`; valid from the `done` cycle until the next `done`.
- `done` out 1: one-cycle pulse when a byte completes.
- `firstbyte` out 1: updated with `done`; 1 when the completed byte was the first since `cs` fell.
- `busy` out 1: 1 while a transfer, the done cycle, or teardown is in progress.
- `sck` out 1: SPI clock; idles at 0.
- `mosi` out 1: serial data out.
- `miso` in 1: serial data in; assumed already synchronous to `clk`.
- `cs` out 1: chip-select, active-low; idles at 1.

## Operation
- State machine: IDLE, SETUP, SHIFT_HI, SHIFT_LO, DONE, WAIT, HOLDOFF, DESELECT.
- IDLE (`cs`=1, `busy`=0): `start`=1 latches `txdata` → SETUP. `cs`=0 and `mosi`=bit 7 from the next cycle; the first-byte flag is set.
- SETUP lasts CLKDIV cycles → SHIFT_HI.
- SHIFT_HI (`sck`=1) lasts CLKDIV cycles. `miso` is shifted into the receive register on the last cycle of the phase → SHIFT_LO.
- SHIFT_LO (`sck`=0) lasts CLKDIV cycles. `mosi` presents the next bit from the start of the phase. After the 8th bit → DONE, otherwise → SHIFT_HI.
- DONE (one cycle): `done`=1, `rxdata` and `firstbyte` update, `busy`=1.
  - `hold`=1 → WAIT.
  - `hold`=0 → HOLDOFF.
- WAIT (`cs`=0, `sck`=0, `mosi`=0, `busy`=0):
  - `start`=1 latches `txdata` → SHIFT_HI, skipping SETUP; the first-byte flag is cleared.
  - `start`=0 with `hold`=0 → HOLDOFF.
  - `start` has priority over `hold`.
- HOLDOFF: CLKDIV cycles with `cs`=0 → DESELECT.
- DESELECT: CLKDIV cycles with `cs`=1 (minimum deselect time) → IDLE.
- `start` while `busy`=1 is ignored; no queueing.
- Reset values: `cs`=1, `sck`=0, `mosi`=0, `rxdata`=0, `done`=0, `firstbyte`=0, `busy`=0, state IDLE.
- `rst` mid-transfer aborts immediately. `cs` returns to 1 on the next edge, with no teardown and no `done`.
- Half-period counter is `$clog2(CLKDIV+1)` bits wide. CLKDIV=1 gives `sck` = clk/2.

## Timing
- Counting the `start` acceptance cycle as cycle 0:
  - `cs` falls at cycle 1.
  - First `sck` rise at cycle 1+CLKDIV.
  - `done` at cycle 17·CLKDIV+1 (CLKDIV=2 → cycle 35; CLKDIV=1 → cycle 18).
- From WAIT: `done` at 16·CLKDIV+1 after acceptance.
- After a non-held `done`: `cs` rises CLKDIV+1 cycles later. `busy` falls 2·CLKDIV+1 cycles after `done`.
- Sampling: `miso` is captured CLKDIV−1 cycles after the `sck` rise, before the fall. `mosi` is stable across every rising edge.

## Configuration
- `SPIMASTER_LSBFIRST_EN`:
  - Defined: bits are transmitted and received LSB first. The first `mosi` bit is `txdata[0]`, and the first sampled bit lands in `rxdata[0]`.
  - Undefined (default): MSB first.
  - Timing is identical in both cases.

## Test plan
- Reset: hold `rst` 5 cycles, then release → `cs`=1, `sck`=0, `mosi`=0, `busy`=0, `rxdata`=0x00, with no `done`.
- Single byte, CLKDIV=2: `txdata`=0xA5 with `hold`=0, bench slave returns 0x8A. Required response:
  - `mosi` sampled at `sck` rises = 1,0,1,0,0,1,0,1.
  - `done` at cycle 35 with `rxdata`=0x8A and `firstbyte`=1.
  - `cs` high at cycle 38; `busy` low at cycle 40.
- Held frame: 0x01 with `hold`=1, then `start` 0x02 in WAIT, then drop `hold`. Required response:
  - `cs` stays 0 between the bytes.
  - Second `done` 33 cycles after its `start`, with `firstbyte`=0.
  - Deselect follows.
- `start` pulsed during SHIFT_HI and again during DONE → ignored; exactly one `done`.
- `rst` asserted at cycle 10 of a transfer → `cs`=1 and `sck`=0 on the next edge, no `done`. A new `start` then completes normally.
- With `SPIMASTER_LSBFIRST_EN` and CLKDIV=1: send 0x01, slave returns 0x80 → first `mosi` bit = 1, `rxdata`=0x80, `done` at cycle 18.

Source files
------------

// File: rtl/spimaster_if.sv
// Byte-transfer handshake and SPI pin bundle between spimaster and its user.
// The master modport is the spimaster side; the slave modport is the controlling/peripheral side.
interface spimaster_if;
  logic       start;
  logic       hold;
  logic [7:0] txdata;
  logic [7:0] rxdata;
  logic       done;
  logic       firstbyte;
  logic       busy;
  logic       sck;
  logic       mosi;
  logic       miso;
  logic       cs;

  modport master (
    input  start, hold, txdata, miso,
    output rxdata, done, firstbyte, busy, sck, mosi, cs
  );

  modport slave (
    output start, hold, txdata, miso,
    input  rxdata, done, firstbyte, busy, sck, mosi, cs
  );
endinterface

// File: rtl/spimaster.sv
// Byte-oriented SPI master, mode 0, with start/busy/done handshake and held multi-byte frames.
// Define SPIMASTER_LSBFIRST_EN to shift LSB first; default is MSB first.
module spimaster #(
  parameter int CLKDIV = 2
) (
  input  logic        clk,
  input  logic        rst,
  spimaster_if.master bus
);

  localparam int CNT_W = $clog2(CLKDIV + 1);

`ifdef SPIMASTER_LSBFIRST_EN
  localparam int TX_BIT = 0;
`else
  localparam int TX_BIT = 7;
`endif

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    SHIFT_HI,
    SHIFT_LO,
    DONE,
    WAIT,
    HOLDOFF,
    DESELECT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       tx_shift_q, tx_shift_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             first_q, first_d;
  logic [7:0]       rxdata_q, rxdata_d;
  logic             firstbyte_q, firstbyte_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             cs_q, cs_d;

  logic             cnt_last;
  logic [CNT_W-1:0] cnt_inc;
  logic [7:0]       tx_next;
  logic [7:0]       rx_next;

  assign cnt_last = (cnt_q == CNT_W'(CLKDIV - 1));
  assign cnt_inc  = cnt_q + 1'b1;

`ifdef SPIMASTER_LSBFIRST_EN
  assign tx_next = {1'b0, tx_shift_q[7:1]};
  assign rx_next = {bus.miso, rx_shift_q[7:1]};
`else
  assign tx_next = {tx_shift_q[6:0], 1'b0};
  assign rx_next = {rx_shift_q[6:0], bus.miso};
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    bit_cnt_d   = bit_cnt_q;
    tx_shift_d  = tx_shift_q;
    rx_shift_d  = rx_shift_q;
    first_d     = first_q;
    rxdata_d    = rxdata_q;
    firstbyte_d = firstbyte_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          tx_shift_d = bus.txdata;
          bit_cnt_d  = 3'd0;
          cnt_d      = '0;
          first_d    = 1'b1;
          state_d    = SETUP;
        end
      end

      SETUP: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = SHIFT_HI;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      // Sample miso just before the falling edge; the next mosi bit goes out with it.
      SHIFT_HI: begin
        if (cnt_last) begin
          rx_shift_d = rx_next;
          tx_shift_d = tx_next;
          cnt_d      = '0;
          state_d    = SHIFT_LO;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      SHIFT_LO: begin
        if (cnt_last) begin
          cnt_d = '0;
          if (bit_cnt_q == 3'd7) begin
            rxdata_d    = rx_shift_q;
            firstbyte_d = first_q;
            state_d     = DONE;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            state_d   = SHIFT_HI;
          end
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DONE: begin
        cnt_d   = '0;
        state_d = bus.hold ? WAIT : HOLDOFF;
      end

      // A held frame resumes straight into the shift phase; cs never went high.
      WAIT: begin
        if (bus.start) begin
          tx_shift_d = bus.txdata;
          bit_cnt_d  = 3'd0;
          cnt_d      = '0;
          first_d    = 1'b0;
          state_d    = SHIFT_HI;
        end else if (!bus.hold) begin
          cnt_d   = '0;
          state_d = HOLDOFF;
        end
      end

      HOLDOFF: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = DESELECT;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      DESELECT: begin
        if (cnt_last) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_inc;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase

    // Pins are registered from the next state so they change cleanly on the clock edge.
    done_d = (state_d == DONE);
    sck_d  = (state_d == SHIFT_HI);
    cs_d   = (state_d == IDLE) || (state_d == DESELECT);
    busy_d = !((state_d == IDLE) || (state_d == WAIT));
    mosi_d = 1'b0;
    if ((state_d == SETUP) || (state_d == SHIFT_HI) || (state_d == SHIFT_LO)) begin
      mosi_d = tx_shift_d[TX_BIT];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= 3'd0;
      tx_shift_q  <= 8'h00;
      rx_shift_q  <= 8'h00;
      first_q     <= 1'b0;
      rxdata_q    <= 8'h00;
      firstbyte_q <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      sck_q       <= 1'b0;
      mosi_q      <= 1'b0;
      cs_q        <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      tx_shift_q  <= tx_shift_d;
      rx_shift_q  <= rx_shift_d;
      first_q     <= first_d;
      rxdata_q    <= rxdata_d;
      firstbyte_q <= firstbyte_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      sck_q       <= sck_d;
      mosi_q      <= mosi_d;
      cs_q        <= cs_d;
    end
  end

  assign bus.rxdata    = rxdata_q;
  assign bus.firstbyte = firstbyte_q;
  assign bus.done      = done_q;
  assign bus.busy      = busy_q;
  assign bus.sck       = sck_q;
  assign bus.mosi      = mosi_q;
  assign bus.cs        = cs_q;

endmodule

// File: tb/tb_spimaster.sv
// Directed bench for spimaster with a mode-0 slave model on miso.
// Cycle n counts clock periods after the edge that accepted start (cs falls in cycle 1).
module tb_spimaster;

`ifdef SPIMASTER_LSBFIRST_EN
  localparam int         CLKDIV = 1;
  localparam bit         LSB    = 1'b1;
  localparam logic [7:0] TX_A   = 8'h01;
  localparam logic [7:0] RESP_A = 8'h80;
`else
  localparam int         CLKDIV = 2;
  localparam bit         LSB    = 1'b0;
  localparam logic [7:0] TX_A   = 8'hA5;
  localparam logic [7:0] RESP_A = 8'h8A;
`endif

  localparam int DONE_CYC  = 17 * CLKDIV + 1;
  localparam int WDONE_CYC = 16 * CLKDIV + 1;

  logic clk;
  logic rst;

  spimaster_if bus ();

  spimaster #(.CLKDIV(CLKDIV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int assert_cnt = 0;
  int fail_cnt   = 0;

  logic [7:0] resp_list [0:1];
  logic [7:0] cur_bits;
  logic [7:0] last_bits;
  int         s_byte;
  int         s_bit;
  logic       s_prev_sck;

  function automatic logic order_bit(input logic [7:0] b, input int i);
    if (i > 7) return 1'b0;
    return LSB ? b[i] : b[7 - i];
  endfunction

  function automatic logic [7:0] exp_bits(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = order_bit(b, i);
    return r;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert_cnt++;
    assert (obs === exp) else begin
      fail_cnt++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic h);
    @(negedge clk);
    bus.txdata = d;
    bus.hold   = h;
    bus.start  = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Mode-0 slave: miso changes after each sck fall, mosi is captured at each sck rise.
  initial begin
    bus.miso   = 1'b0;
    s_prev_sck = 1'b0;
    s_byte     = 0;
    s_bit      = 0;
    cur_bits   = 8'h00;
    last_bits  = 8'h00;
    forever begin
      @(negedge clk);
      if (bus.cs !== 1'b0) begin
        s_byte   = 0;
        s_bit    = 0;
        cur_bits = 8'h00;
        bus.miso = order_bit(resp_list[0], 0);
      end else begin
        if (bus.sck === 1'b1 && s_prev_sck === 1'b0 && s_bit < 8) cur_bits[s_bit] = bus.mosi;
        if (bus.sck === 1'b0 && s_prev_sck === 1'b1) begin
          s_bit++;
          bus.miso = order_bit(resp_list[s_byte], s_bit);
        end
        if (bus.done === 1'b1) begin
          last_bits = cur_bits;
          cur_bits  = 8'h00;
          if (s_byte < 1) s_byte++;
          s_bit    = 0;
          bus.miso = order_bit(resp_list[s_byte], 0);
        end
      end
      s_prev_sck = bus.sck;
    end
  end

  initial begin
    int         done_cnt;
    int         done_at;
    int         cs_hi_at;
    int         busy_lo_at;
    int         cs_hi_cnt;
    logic [7:0] rx_at;
    logic       fb_at;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.hold     = 1'b0;
    bus.txdata   = 8'h00;
    resp_list[0] = RESP_A;
    resp_list[1] = 8'h00;

    $display("[TB] reset");
    repeat (5) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_output("reset_cs", bus.cs, 1);
    check_output("reset_sck", bus.sck, 0);
    check_output("reset_mosi", bus.mosi, 0);
    check_output("reset_busy", bus.busy, 0);
    check_output("reset_rxdata", bus.rxdata, 8'h00);
    check_output("reset_done", bus.done, 0);

    $display("[TB] single byte");
    resp_list[0] = RESP_A;
    apply_stimulus(TX_A, 1'b0);
    done_cnt = 0; done_at = -1; cs_hi_at = -1; busy_lo_at = -1; rx_at = 8'h00; fb_at = 1'b0;
    for (int n = 1; n <= DONE_CYC + 2 * CLKDIV + 4; n++) begin
      @(negedge clk);
      if (n == 1) check_output("cs_fall", bus.cs, 0);
      if (n == CLKDIV) check_output("sck_before_rise", bus.sck, 0);
      if (n == CLKDIV + 1) check_output("sck_first_rise", bus.sck, 1);
      if (bus.done === 1'b1) begin
        done_cnt++; done_at = n; rx_at = bus.rxdata; fb_at = bus.firstbyte;
      end
      if (cs_hi_at < 0 && bus.cs === 1'b1) cs_hi_at = n;
      if (busy_lo_at < 0 && bus.busy === 1'b0) busy_lo_at = n;
    end
    check_output("single_done_cnt", done_cnt, 1);
    check_output("single_done_cycle", done_at, DONE_CYC);
    check_output("single_rxdata", rx_at, RESP_A);
    check_output("single_firstbyte", fb_at, 1);
    check_output("single_cs_rise", cs_hi_at, DONE_CYC + CLKDIV + 1);
    check_output("single_busy_fall", busy_lo_at, DONE_CYC + 2 * CLKDIV + 1);
    for (int i = 0; i < 8; i++) begin
      check_output($sformatf("single_mosi_bit%0d", i), last_bits[i], order_bit(TX_A, i));
    end

    $display("[TB] held frame");
    resp_list[0] = 8'h3C;
    resp_list[1] = 8'hC3;
    apply_stimulus(8'h01, 1'b1);
    done_at = -1; cs_hi_cnt = 0; rx_at = 8'h00; fb_at = 1'b0;
    for (int n = 1; n <= DONE_CYC + 10; n++) begin
      @(negedge clk);
      if (bus.cs !== 1'b0) cs_hi_cnt++;
      if (bus.done === 1'b1) begin
        done_at = n; rx_at = bus.rxdata; fb_at = bus.firstbyte;
        break;
      end
    end
    check_output("held1_done_cycle", done_at, DONE_CYC);
    check_output("held1_rxdata", rx_at, 8'h3C);
    check_output("held1_firstbyte", fb_at, 1);
    check_output("held1_mosi", last_bits, exp_bits(8'h01));
    @(negedge clk);
    check_output("wait_busy", bus.busy, 0);
    check_output("wait_cs", bus.cs, 0);
    check_output("wait_sck", bus.sck, 0);
    apply_stimulus(8'h02, 1'b1);
    bus.hold = 1'b0;
    done_at = -1; cs_hi_at = -1; busy_lo_at = -1; rx_at = 8'h00; fb_at = 1'b1;
    for (int n = 1; n <= WDONE_CYC + 2 * CLKDIV + 4; n++) begin
      @(negedge clk);
      if (bus.cs !== 1'b0 && cs_hi_at < 0) cs_hi_at = n;
      if (bus.done === 1'b1) begin
        done_at = n; rx_at = bus.rxdata; fb_at = bus.firstbyte;
      end
      if (busy_lo_at < 0 && bus.busy === 1'b0) busy_lo_at = n;
    end
    check_output("held_cs_low_frame", cs_hi_cnt, 0);
    check_output("held2_done_cycle", done_at, WDONE_CYC);
    check_output("held2_rxdata", rx_at, 8'hC3);
    check_output("held2_firstbyte", fb_at, 0);
    check_output("held2_mosi", last_bits, exp_bits(8'h02));
    check_output("held2_cs_rise", cs_hi_at, WDONE_CYC + CLKDIV + 1);
    check_output("held2_busy_fall", busy_lo_at, WDONE_CYC + 2 * CLKDIV + 1);

    $display("[TB] start while busy");
    resp_list[0] = 8'h5A;
    apply_stimulus(8'h96, 1'b0);
    done_cnt = 0; done_at = -1; rx_at = 8'h00;
    for (int n = 1; n <= DONE_CYC + 2 * CLKDIV + 6; n++) begin
      @(negedge clk);
      if (n == CLKDIV + 1 || n == DONE_CYC) begin
        bus.start  = 1'b1;
        bus.txdata = 8'hFF;
      end else begin
        bus.start = 1'b0;
      end
      if (n == CLKDIV + 1) check_output("ignore_in_shift_hi", bus.sck, 1);
      if (n == DONE_CYC) check_output("ignore_in_done", bus.done, 1);
      if (bus.done === 1'b1) begin
        done_cnt++; done_at = n; rx_at = bus.rxdata;
      end
    end
    bus.start = 1'b0;
    check_output("ignore_done_cnt", done_cnt, 1);
    check_output("ignore_done_cycle", done_at, DONE_CYC);
    check_output("ignore_rxdata", rx_at, 8'h5A);
    check_output("ignore_mosi", last_bits, exp_bits(8'h96));
    check_output("ignore_end_busy", bus.busy, 0);
    check_output("ignore_end_cs", bus.cs, 1);

    $display("[TB] reset mid-transfer");
    resp_list[0] = 8'h33;
    apply_stimulus(8'h55, 1'b0);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 10) rst = 1'b1;
    end
    @(negedge clk);
    check_output("abort_cs", bus.cs, 1);
    check_output("abort_sck", bus.sck, 0);
    check_output("abort_busy", bus.busy, 0);
    check_output("abort_done", bus.done, 0);
    rst = 1'b0;
    done_cnt = 0;
    for (int n = 0; n < DONE_CYC + 4; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check_output("abort_no_done", done_cnt, 0);
    apply_stimulus(8'h55, 1'b0);
    done_cnt = 0; done_at = -1; rx_at = 8'h00;
    for (int n = 1; n <= DONE_CYC + 2 * CLKDIV + 4; n++) begin
      @(negedge clk);
      if (bus.done === 1'b1) begin
        done_cnt++; done_at = n; rx_at = bus.rxdata;
      end
    end
    check_output("restart_done_cnt", done_cnt, 1);
    check_output("restart_done_cycle", done_at, DONE_CYC);
    check_output("restart_rxdata", rx_at, 8'h33);
    check_output("restart_mosi", last_bits, exp_bits(8'h55));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
